intr_ctrl: RTL and testbench
============================

# intr_ctrl

CPU-side interrupt controller that consumes the stretched `interrupt` pulses produced by per-button interrupt FSMs and presents a single request/acknowledge interface to the MCU control unit. It:

- edge-detects each request line and latches it as pending;
- applies per-source masks and the CPU interrupt-enable flag;
- arbitrates by fixed priority;
- holds the selected source ID stable until the ISR signals completion.

## Interface

Parameters:

- `N_SRC`, default 4: number of interrupt sources (2..8).
- `ID_W`, default 2: width of `int_id`; must equal `$clog2(N_SRC)`.

Ports:

- `clk` input 1: system clock. All request sources are in this domain; no synchronizer is needed.
- `rst_n` input 1: asynchronous, active-low reset.
- `irq` input N_SRC: level request per source, high for ≥1 cycle per event.
- `irq_mask` input N_SRC: per-source enable, 1 = enabled.
- `int_en` input 1: CPU global interrupt-enable flag (I flag).
- `int_ack` input 1: one-cycle pulse from the CPU when it takes the interrupt (PC pushed, vector loaded).
- `int_done` input 1: one-cycle pulse when the CPU executes the return-from-interrupt.
- `int_req` output 1: interrupt request to the CPU.
- `int_id` output ID_W: index of the source being requested or serviced.
- `pending` output N_SRC: latched, not-yet-acknowledged events.
- `overrun` output N_SRC: sticky flag; an event arrived while that source was already pending.

## Operation

Edge detection:
- `irq_q` registers `irq`.
- Event on source i = `irq[i] & ~irq_q[i]`.
- `irq_q` resets to all ones, so a line already high at reset release does not fire; it must fall and rise again.

Pending latch:
- An event sets `pending[i]` regardless of `irq_mask`. Masking only affects arbitration.
- `pending[i]` clears on `int_ack` in REQ when `int_id == i`.
- Event on i in the same cycle as that clear: set wins, so `pending[i]` stays 1 and `overrun[i]` is not set.
- Event on i while `pending[i]` is already 1 and not being cleared: sets `overrun[i]`.
- `overrun[i]` clears only on the `int_ack` of source i, or on reset.

Eligibility: `elig = pending & irq_mask`. Winner = lowest set index of `elig`.

State machine (IDLE, REQ, SERVICE):
- IDLE:
  - If `int_en` and any `elig`: register winner into `int_id`, go to REQ.
  - Otherwise stay in IDLE.
- REQ (`int_req` = 1):
  - `int_ack` → clear `pending[int_id]`, go to SERVICE.
  - Else if `!int_en` or `!elig[int_id]` → return to IDLE; pending bits are unchanged.
  - `int_ack` takes precedence over withdrawal in the same cycle.
- SERVICE (`int_req` = 0):
  - `int_done` → IDLE.
  - No nesting; new events only latch as pending.
  - `int_id` holds its value.

Input qualification:
- `int_ack` is ignored outside REQ.
- `int_done` is ignored outside SERVICE.

Outputs:
- `int_req` is a Moore output: 1 iff state == REQ.
- `int_id` changes only on the IDLE→REQ transition.

## Timing

- Reset values: state IDLE, `int_req` = 0, `int_id` = 0, `pending` = 0, `overrun` = 0, `irq_q` = all ones.
- Reset asserted mid-operation returns immediately to the reset values. Lost pending events are not recovered.
- Latency: `irq[i]` first sampled high at edge k → `pending[i]` = 1 after k → `int_req` = 1 after edge k+1, provided i is eligible and `int_en` = 1. That is 2 cycles.
- `int_ack` sampled high at edge m → after m: `int_req` = 0, `pending[int_id]` = 0, state SERVICE.
- `int_done` sampled at edge d → IDLE after d. The next request can assert after d+1, giving a minimum 1-cycle gap of `int_req` low between services.
- A request held for 7 cycles produces exactly one event.
- `irq_mask` and `int_en` are sampled every cycle with no latching.

## Test plan

- Single event:
  - Stimulus: `N_SRC` = 4, `irq_mask` = 4'b1111, `int_en` = 1; pulse `irq[2]` for 7 cycles.
  - Response: `int_req` high 2 cycles after the first sampled edge, `int_id` = 2. `int_ack` → `pending` = 0, `int_req` low. `int_done` → IDLE. No second request.
- Priority:
  - Stimulus: `irq[3]` and `irq[1]` rise in the same cycle.
  - Response: `int_id` = 1 first. After `int_ack` and `int_done`, `int_id` = 3 with `pending` = 4'b1000 during the second request.
- Mask and enable:
  - Stimulus: `irq_mask` = 4'b1110, event on `irq[0]`.
  - Response: `pending` = 4'b0001, `int_req` stays 0.
  - Stimulus: set `irq_mask[0]` = 1 with `int_en` = 0.
  - Response: still 0.
  - Stimulus: raise `int_en`.
  - Response: `int_req` after 1 cycle, `int_id` = 0.
- Withdrawal:
  - Stimulus: drop `int_en` while in REQ, no `int_ack`.
  - Response: `int_req` 0 next cycle, `pending` retained, and the request reasserts when `int_en` returns.
- Overrun and collision:
  - Stimulus: second event on `irq[1]` while it is pending.
  - Response: `overrun` = 4'b0010.
  - Stimulus: an event on the same source in the `int_ack` cycle.
  - Response: `pending[1]` stays 1 and `overrun[1]` = 0.
- Reset:
  - Stimulus: assert `rst_n` = 0 during SERVICE with `irq[0]` held high; release.
  - Response: all outputs 0, and no event until `irq[0]` falls and rises again.

Source files
------------

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detects per-source requests, latches them as pending,
// and presents the fixed-priority winner to the CPU through a req/ack/done handshake.
module intr_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  irq,
  input  logic [N_SRC-1:0]  irq_mask,
  input  logic              int_en,
  input  logic              int_ack,
  input  logic              int_done,
  output logic              int_req,
  output logic [ID_W-1:0]   int_id,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  overrun
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] event_v;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  winner;
  logic             ack_take;

  assign event_v  = irq & ~irq_q;
  assign elig     = pending & irq_mask;
  assign ack_take = (state == REQ) && int_ack;

  always_comb begin
    clr = '0;
    if (ack_take) clr[int_id] = 1'b1;
  end

  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  // irq_q resets high so a line already asserted at reset release cannot fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '1;
      pending <= '0;
      overrun <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr) | event_v;
      overrun <= (overrun & ~clr) | (event_v & pending & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      int_req <= 1'b0;
      int_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (int_en && (|elig)) begin
            int_id  <= winner;
            state   <= REQ;
            int_req <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state   <= SERVICE;
            int_req <= 1'b0;
          end else if (!int_en || !elig[int_id]) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (int_done) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl with hand-computed expectations.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq;
  logic [3:0] irq_mask;
  logic       int_en;
  logic       int_ack;
  logic       int_done;
  logic       int_req;
  logic [1:0] int_id;
  logic [3:0] pending;
  logic [3:0] overrun;

  int checks = 0;
  int errors = 0;

  intr_ctrl #(.N_SRC(4), .ID_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq      (irq),
    .irq_mask (irq_mask),
    .int_en   (int_en),
    .int_ack  (int_ack),
    .int_done (int_done),
    .int_req  (int_req),
    .int_id   (int_id),
    .pending  (pending),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] i, input logic [3:0] m, input logic en,
                               input logic ack, input logic done);
    irq      = i;
    irq_mask = m;
    int_en   = en;
    int_ack  = ack;
    int_done = done;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    step(2);
    checkOutput("rst_req", 32'(int_req), 32'h0);
    checkOutput("rst_id", 32'(int_id), 32'h0);
    checkOutput("rst_pend", 32'(pending), 32'h0);
    checkOutput("rst_ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Single event on source 2, held 7 sampled cycles
    applyStimulus(4'b0100, 4'b1111, 1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("single_pend", 32'(pending), 32'h4);
    checkOutput("single_req_early", 32'(int_req), 32'h0);
    step(1);
    checkOutput("single_req", 32'(int_req), 32'h1);
    checkOutput("single_id", 32'(int_id), 32'h2);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    checkOutput("single_ack_req", 32'(int_req), 32'h0);
    checkOutput("single_ack_pend", 32'(pending), 32'h0);
    step(4);
    irq = 4'b0000;
    checkOutput("single_svc_req", 32'(int_req), 32'h0);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    step(2);
    checkOutput("single_no_second", 32'(int_req), 32'h0);
    checkOutput("single_pend_end", 32'(pending), 32'h0);

    // Priority: sources 3 and 1 together
    irq = 4'b1010;
    step(1);
    irq = 4'b0000;
    checkOutput("prio_pend", 32'(pending), 32'ha);
    step(1);
    checkOutput("prio_req1", 32'(int_req), 32'h1);
    checkOutput("prio_id1", 32'(int_id), 32'h1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    checkOutput("prio_pend_after_ack", 32'(pending), 32'h8);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    checkOutput("prio_gap", 32'(int_req), 32'h0);
    step(1);
    checkOutput("prio_req2", 32'(int_req), 32'h1);
    checkOutput("prio_id2", 32'(int_id), 32'h3);
    checkOutput("prio_pend2", 32'(pending), 32'h8);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;

    // Mask and global enable
    applyStimulus(4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0);
    step(1);
    irq = 4'b0000;
    checkOutput("mask_pend", 32'(pending), 32'h1);
    step(2);
    checkOutput("mask_req", 32'(int_req), 32'h0);
    irq_mask = 4'b1111;
    int_en = 1'b0;
    step(2);
    checkOutput("en_off_req", 32'(int_req), 32'h0);
    int_en = 1'b1;
    step(1);
    checkOutput("en_on_req", 32'(int_req), 32'h1);
    checkOutput("en_on_id", 32'(int_id), 32'h0);

    // Withdrawal while requesting
    int_en = 1'b0;
    step(1);
    checkOutput("wd_req", 32'(int_req), 32'h0);
    checkOutput("wd_pend", 32'(pending), 32'h1);
    int_en = 1'b1;
    step(1);
    checkOutput("wd_reassert", 32'(int_req), 32'h1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    checkOutput("wd_pend_clear", 32'(pending), 32'h0);

    // Overrun, then an event colliding with the acknowledge
    irq = 4'b0010;
    step(1);
    irq = 4'b0000;
    step(1);
    checkOutput("ovr_id", 32'(int_id), 32'h1);
    irq = 4'b0010;
    step(1);
    irq = 4'b0000;
    checkOutput("ovr_flag", 32'(overrun), 32'h2);
    step(1);
    irq = 4'b0010;
    int_ack = 1'b1;
    step(1);
    irq = 4'b0000;
    int_ack = 1'b0;
    checkOutput("coll_pend", 32'(pending), 32'h2);
    checkOutput("coll_ovr", 32'(overrun), 32'h0);
    checkOutput("coll_req", 32'(int_req), 32'h0);
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;
    step(1);
    checkOutput("coll_rereq", 32'(int_req), 32'h1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    int_done = 1'b1;
    step(1);
    int_done = 1'b0;

    // Reset during service with irq[0] held high
    irq = 4'b0001;
    step(2);
    checkOutput("rs_req", 32'(int_req), 32'h1);
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rs_async_pend", 32'(pending), 32'h0);
    checkOutput("rs_async_req", 32'(int_req), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(3);
    checkOutput("rs_held_pend", 32'(pending), 32'h0);
    checkOutput("rs_held_req", 32'(int_req), 32'h0);
    irq = 4'b0000;
    step(1);
    irq = 4'b0001;
    step(1);
    checkOutput("rs_refire_pend", 32'(pending), 32'h1);
    step(1);
    checkOutput("rs_refire_req", 32'(int_req), 32'h1);
    checkOutput("rs_refire_id", 32'(int_id), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
